// File: rtl/bp_pkg.sv
// Shared branch-prediction types and defaults.
// Also used by the neural_predictor glue logic.
package bp_pkg;

  localparam int PC_W  = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            predicted;
  } bp_entry_t;

  function automatic logic is_mispredict(input logic predicted, input logic actual);
    return predicted ^ actual;
  endfunction

endpackage

// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction FIFO. Resolving the oldest entry trains the predictor.
// A wrong direction discards every younger entry.
module branch_resolve_queue
  import bp_pkg::is_mispredict;
#(
  parameter int PC_W  = bp_pkg::PC_W,
  parameter int DEPTH = bp_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic                     resolve_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  r_mem_pc   [DEPTH];
  logic             r_mem_pred [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_err;
  logic             w_mis;

  assign pred_ready = (r_count < CNT_W'(DEPTH));
  assign count      = r_count;
  assign w_push     = pred_valid & pred_ready;
  assign w_pop      = resolve_valid & (r_count != {CNT_W{1'b0}});
  assign w_err      = resolve_valid & (r_count == {CNT_W{1'b0}});
  assign w_mis      = w_pop & is_mispredict(r_mem_pred[r_rd_ptr], resolve_taken);

  // Next occupancy; a mispredict flushes everything, including a same-cycle push.
  always_comb begin
    w_count_nxt = r_count;
    if (w_mis) begin
      w_count_nxt = {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      r_count <= w_count_nxt;
      if (w_mis) begin
        r_rd_ptr <= {PTR_W{1'b0}};
        r_wr_ptr <= {PTR_W{1'b0}};
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push && !w_mis) begin
      r_mem_pc[r_wr_ptr]   <= pred_pc;
      r_mem_pred[r_wr_ptr] <= pred_taken;
    end
  end

  // Registered training / status outputs; pc and outcome hold between updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_pc      <= {PC_W{1'b0}};
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      upd_valid   <= w_pop;
      mispredict  <= w_mis;
      resolve_err <= w_err;
      if (w_pop) begin
        upd_pc    <= r_mem_pc[r_rd_ptr];
        upd_taken <= resolve_taken;
      end
    end
  end

endmodule
